// File: rtl/audio_dac_player.sv
// audio_dac_player: one-sample-buffered I2S DAC serializer, slaved to the codec's BCLK/DACLRCK.
// The codec clocks are synchronized into i_clk. Each channel's 16 bits go out MSB first,
// starting on the second BCLK fall after the LRCK edge.
// Optional feature macro: AUDIO_DAC_MUTE_ON_UNDERRUN_EN. When defined, an underrun frame is silence.
// When undefined, an underrun frame repeats the previous frame.
module audio_dac_player #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_audio_valid,
    input  logic [31:0] i_audio_data,
    output logic        o_audio_ready,
    input  logic        i_bclk,
    input  logic        i_daclrck,
    output logic        o_dacdat,
    output logic        o_underrun
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_LEFT       = 2'd2,
        S_RIGHT      = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrck_sync;
    logic                   r_bclk_hist;
    logic                   r_lrck_hist;

    logic [31:0] r_hold_data;
    logic        r_hold_valid;
    logic        r_ready;
    logic [31:0] r_frame;
    logic [15:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic        r_dacdat;
    logic        r_underrun;

    logic        w_bclk_fall;
    logic        w_lrck_fall;
    logic        w_lrck_rise;
    logic        w_accept;
    logic        w_load;
    logic        w_start_right;
    logic        w_hold_next;
    logic [31:0] w_frame_next;

    // Bring the asynchronous codec clocks into i_clk; the extra history flop gives edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_bclk_hist <= 1'b0;
            r_lrck_hist <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i_bclk};
            r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], i_daclrck};
            r_bclk_hist <= r_bclk_sync[SYNC_STAGES-1];
            r_lrck_hist <= r_lrck_sync[SYNC_STAGES-1];
        end
    end

    assign w_bclk_fall = r_bclk_hist & ~r_bclk_sync[SYNC_STAGES-1];
    assign w_lrck_fall = r_lrck_hist & ~r_lrck_sync[SYNC_STAGES-1];
    assign w_lrck_rise = ~r_lrck_hist & r_lrck_sync[SYNC_STAGES-1];

    assign w_accept = i_audio_valid & r_ready;

`ifdef AUDIO_DAC_MUTE_ON_UNDERRUN_EN
    assign w_frame_next = r_hold_valid ? r_hold_data : 32'h0000_0000;
`else
    assign w_frame_next = r_hold_valid ? r_hold_data : r_frame;
`endif

    // Buffer occupancy: disable flushes the buffer, accept fills it, a frame load drains it
    always_comb begin
        w_hold_next = r_hold_valid;
        if (!i_en) begin
            w_hold_next = 1'b0;
        end else if (w_accept) begin
            w_hold_next = 1'b1;
        end else if (w_load) begin
            w_hold_next = 1'b0;
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and the frame-load / channel-switch strobes; disable overrides everything
    always_comb begin
        w_state_next  = r_state;
        w_load        = 1'b0;
        w_start_right = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_WAIT_FRAME;
            end
            S_WAIT_FRAME: begin
                if (w_lrck_fall) begin
                    w_state_next = S_LEFT;
                    w_load       = 1'b1;
                end
            end
            S_LEFT: begin
                if (w_lrck_rise) begin
                    w_state_next  = S_RIGHT;
                    w_start_right = 1'b1;
                end
            end
            S_RIGHT: begin
                if (w_lrck_fall) begin
                    w_state_next = S_LEFT;
                    w_load       = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (!i_en) begin
            w_state_next  = S_IDLE;
            w_load        = 1'b0;
            w_start_right = 1'b0;
        end
    end

    // Holding register and registered ready flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold_data <= i_audio_data;
            end
            r_hold_valid <= w_hold_next;
            r_ready      <= i_en & ~w_hold_next;
        end
    end

    // Frame load, channel start and per-BCLK-fall bit shifting; LRCK edges restart the counter (truncation)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame    <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_dacdat   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (!i_en) begin
                r_dacdat  <= 1'b0;
                r_bit_cnt <= '0;
            end else if (w_load) begin
                r_frame    <= w_frame_next;
                r_shift    <= w_frame_next[31:16];
                r_bit_cnt  <= '0;
                r_underrun <= ~r_hold_valid;
            end else if (w_start_right) begin
                r_shift   <= r_frame[15:0];
                r_bit_cnt <= '0;
            end else if (w_bclk_fall && (r_state == S_LEFT || r_state == S_RIGHT)) begin
                if (r_bit_cnt < 5'd16) begin
                    r_dacdat  <= r_shift[15];
                    r_shift   <= {r_shift[14:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end else begin
                    r_dacdat <= 1'b0;
                end
            end
        end
    end

    assign o_audio_ready = r_ready;
    assign o_dacdat      = r_dacdat;
    assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_audio_dac_player.sv
// Directed bench for audio_dac_player: the bench plays codec master (BCLK/LRCK) and mixer.
// It captures o_dacdat on each BCLK rise and compares against hand-computed words.
module tb_audio_dac_player;

    logic        i_clk;
    logic        i_rst;
    logic        i_en;
    logic        i_audio_valid;
    logic [31:0] i_audio_data;
    logic        o_audio_ready;
    logic        i_bclk;
    logic        i_daclrck;
    logic        o_dacdat;
    logic        o_underrun;

    int n_checks;
    int n_errors;
    int ur_cycles;

    logic [31:0] feed_q[$];
    logic        pending;

    audio_dac_player #(.SYNC_STAGES(2)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .i_audio_valid (i_audio_valid),
        .i_audio_data  (i_audio_data),
        .o_audio_ready (o_audio_ready),
        .i_bclk        (i_bclk),
        .i_daclrck     (i_daclrck),
        .o_dacdat      (o_dacdat),
        .o_underrun    (o_underrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Count every cycle the underrun pulse is high
    always @(negedge i_clk) begin
        if (o_underrun === 1'b1) ur_cycles++;
    end

    // Mixer model: offers the queue head; pops after the edge that accepted it
    initial begin
        i_audio_valid = 1'b0;
        i_audio_data  = '0;
        pending       = 1'b0;
        forever begin
            @(negedge i_clk);
            if (pending && feed_q.size() > 0) void'(feed_q.pop_front());
            if (feed_q.size() > 0) begin
                i_audio_valid = 1'b1;
                i_audio_data  = feed_q[0];
            end else begin
                i_audio_valid = 1'b0;
            end
            pending = i_audio_valid & o_audio_ready;
        end
    end

    // One channel of nper BCLK periods; the first fall coincides with the LRCK edge.
    // Bits are captured on BCLK rises after that first period.
    task automatic channel(input logic lr, input int nper, output logic [15:0] word,
                           output int nbits, output logic tail_nz);
        word = '0; nbits = 0; tail_nz = 1'b0;
        for (int k = 0; k < nper; k++) begin
            i_bclk = 1'b0;
            if (k == 0) i_daclrck = lr;
            #40;
            i_bclk = 1'b1;
            if (k > 0) begin
                if (nbits < 16) begin
                    word = {word[14:0], o_dacdat};
                    nbits++;
                end else if (o_dacdat !== 1'b0) begin
                    tail_nz = 1'b1;
                end
            end
            #40;
        end
    endtask

    task automatic play_frame(input int nper, input logic [15:0] exp_l, input logic [15:0] exp_r,
                              input string tag);
        logic [15:0] w;
        int nb;
        logic tz;
        channel(1'b0, nper, w, nb, tz);
        check({tag, "_left"}, {16'h0, w}, {16'h0, exp_l});
        check({tag, "_ltail"}, {31'h0, tz}, 32'h0);
        channel(1'b1, nper, w, nb, tz);
        check({tag, "_right"}, {16'h0, w}, {16'h0, exp_r});
        check({tag, "_rtail"}, {31'h0, tz}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int nb;
        logic tz;
        logic [15:0] ur_l;
        logic [15:0] ur_r;
        n_checks = 0; n_errors = 0; ur_cycles = 0;
        i_rst = 1'b1; i_en = 1'b0; i_bclk = 1'b0; i_daclrck = 1'b1;

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_dacdat", {31'h0, o_dacdat}, 32'h0);
        check("rst_ready", {31'h0, o_audio_ready}, 32'h0);
        check("rst_underrun", {31'h0, o_underrun}, 32'h0);
        i_rst = 1'b0;
        i_en  = 1'b1;
        repeat (4) @(negedge i_clk);
        check("en_ready", {31'h0, o_audio_ready}, 32'h1);

        // Basic sample: MSB on second fall
        feed_q.push_back(32'h8001_7FFE);
        repeat (4) @(negedge i_clk);
        check("hold_ready", {31'h0, o_audio_ready}, 32'h0);
        play_frame(20, 16'h8001, 16'h7FFE, "basic");
        check("basic_ur", ur_cycles, 0);

        // Continuous stream of four frames
        feed_q.push_back(32'h1111_2222);
        feed_q.push_back(32'h3333_4444);
        feed_q.push_back(32'h5555_6666);
        feed_q.push_back(32'h7777_8888);
        repeat (4) @(negedge i_clk);
        channel(1'b0, 20, w, nb, tz);
        check("s0_left", {16'h0, w}, 32'h1111);
        check("s0_ready", {31'h0, o_audio_ready}, 32'h0);
        channel(1'b1, 20, w, nb, tz);
        check("s0_right", {16'h0, w}, 32'h2222);
        channel(1'b0, 20, w, nb, tz);
        check("s1_left", {16'h0, w}, 32'h3333);
        check("s1_ready", {31'h0, o_audio_ready}, 32'h0);
        channel(1'b1, 20, w, nb, tz);
        check("s1_right", {16'h0, w}, 32'h4444);
        channel(1'b0, 20, w, nb, tz);
        check("s2_left", {16'h0, w}, 32'h5555);
        check("s2_ready", {31'h0, o_audio_ready}, 32'h0);
        channel(1'b1, 20, w, nb, tz);
        check("s2_right", {16'h0, w}, 32'h6666);
        channel(1'b0, 20, w, nb, tz);
        check("s3_left", {16'h0, w}, 32'h7777);
        check("s3_ready", {31'h0, o_audio_ready}, 32'h1);
        channel(1'b1, 20, w, nb, tz);
        check("s3_right", {16'h0, w}, 32'h8888);
        check("stream_ur", ur_cycles, 0);

        // Underrun after 1234_5678
        feed_q.push_back(32'h1234_5678);
        repeat (4) @(negedge i_clk);
        play_frame(20, 16'h1234, 16'h5678, "pre_ur");
`ifdef AUDIO_DAC_MUTE_ON_UNDERRUN_EN
        ur_l = 16'h0000; ur_r = 16'h0000;
`else
        ur_l = 16'h1234; ur_r = 16'h5678;
`endif
        play_frame(20, ur_l, ur_r, "ur_frame");
        check("ur_pulse", ur_cycles, 1);

        // Truncated 12-period channels, then a full frame
        feed_q.push_back(32'hA5C3_3CA5);
        feed_q.push_back(32'hABCD_1234);
        repeat (4) @(negedge i_clk);
        channel(1'b0, 12, w, nb, tz);
        check("trunc_lbits", nb, 11);
        check("trunc_left", {16'h0, w}, 32'h052E);
        channel(1'b1, 12, w, nb, tz);
        check("trunc_right", {16'h0, w}, 32'h01E5);
        play_frame(20, 16'hABCD, 16'h1234, "after_trunc");
        check("trunc_ur", ur_cycles, 1);

        // Disable mid-left at bit 7, then re-enable
        feed_q.push_back(32'hC3A5_0000);
        repeat (4) @(negedge i_clk);
        channel(1'b0, 8, w, nb, tz);
        check("dis_left7", {16'h0, w}, 32'h0061);
        @(negedge i_clk);
        i_en = 1'b0;
        @(negedge i_clk);
        check("dis_dacdat", {31'h0, o_dacdat}, 32'h0);
        check("dis_ready", {31'h0, o_audio_ready}, 32'h0);
        channel(1'b1, 20, w, nb, tz);
        check("dis_right", {16'h0, w}, 32'h0);
        i_en = 1'b1;
        feed_q.push_back(32'h5A5A_C3C3);
        repeat (4) @(negedge i_clk);
        play_frame(20, 16'h5A5A, 16'hC3C3, "reen");
        check("reen_ur", ur_cycles, 1);

        // Asynchronous reset mid-right
        feed_q.push_back(32'hDEAD_BEEF);
        repeat (4) @(negedge i_clk);
        channel(1'b0, 20, w, nb, tz);
        check("z_left", {16'h0, w}, 32'hDEAD);
        channel(1'b1, 8, w, nb, tz);
        check("z_right7", {16'h0, w}, 32'h005F);
        check("pre_rst_dacdat", {31'h0, o_dacdat}, 32'h1);
        check("pre_rst_ready", {31'h0, o_audio_ready}, 32'h1);
        #2;
        i_rst = 1'b1;
        #1;
        check("arst_dacdat", {31'h0, o_dacdat}, 32'h0);
        check("arst_ready", {31'h0, o_audio_ready}, 32'h0);
        check("arst_underrun", {31'h0, o_underrun}, 32'h0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        check("post_rst_ready", {31'h0, o_audio_ready}, 32'h1);
        feed_q.push_back(32'h0F0F_A50A);
        repeat (4) @(negedge i_clk);
        channel(1'b1, 20, w, nb, tz);
        check("post_rst_idle", {16'h0, w}, 32'h0);
        play_frame(20, 16'h0F0F, 16'hA50A, "post_rst");
        check("final_ur", ur_cycles, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
